// File: rtl/pll_ctrl_pkg.sv
// Shared types and reset defaults for the PLL divider/lock controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_BLANK,
    ST_WAIT_LOCK,
    ST_RUN,
    ST_FAULT
  } pll_ctrl_state_e;

  // Dividers driven to the PLL out of reset (divide-by-one on both paths).
  localparam int unsigned DEFAULT_REFDIV = 1;
  localparam int unsigned DEFAULT_FBDIV  = 1;

endpackage

// File: rtl/pll_ctrl_sync_2ff.sv
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
// Latency: 2 clk cycles from input change to q.
// Backpressure: none; pure level synchroniser.
module pll_ctrl_sync_2ff (
  input  logic clk,
  input  logic arst_ni,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; first stage may go metastable, second resolves it.
  always_ff @(posedge clk or negedge arst_ni) begin
    if (!arst_ni) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_ctrl.sv
// Programs PLL dividers on request and gates the PLL output until lock is stable; optional PLL_CTRL_AUTO_RETRY_EN.
// Latency: dividers update on the accept edge; lock declared after 1 + BLANK_CYCLES + LOCK_STABLE_CYCLES (+2 sync) cycles.
// Backpressure: req_ready_o low while applying/blanking/waiting for lock; requests stall, never dropped.
module pll_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned REF_DIV_WIDTH       = 4,
  parameter int unsigned FB_DIV_WIDTH        = 8,
  parameter int unsigned BLANK_CYCLES        = 8,
  parameter int unsigned LOCK_STABLE_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic                     arst_ni,
  input  logic                     clk_ref_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [REF_DIV_WIDTH-1:0] req_refdiv_i,
  input  logic [FB_DIV_WIDTH-1:0]  req_fbdiv_i,
  output logic [REF_DIV_WIDTH-1:0] refdiv_o,
  output logic [FB_DIV_WIDTH-1:0]  fbdiv_o,
  input  logic                     pll_locked_i,
  output logic                     clk_gate_en_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     lock_lost_o,
  output logic                     err_param_o,
  output logic                     err_timeout_o
);

  localparam int unsigned TMO_W   = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int unsigned BLANK_W = $clog2(BLANK_CYCLES + 1);
  localparam int unsigned STAB_W  = $clog2(LOCK_STABLE_CYCLES + 1);

  localparam logic [TMO_W-1:0]   TMO_MAX   = TMO_W'(LOCK_TIMEOUT_CYCLES);
  localparam logic [BLANK_W-1:0] BLANK_END = BLANK_W'(BLANK_CYCLES - 1);
  localparam logic [STAB_W-1:0]  STAB_MAX  = STAB_W'(LOCK_STABLE_CYCLES);

  pll_ctrl_state_e          state_q, state_d;
  logic [REF_DIV_WIDTH-1:0] refdiv_q, refdiv_d;
  logic [FB_DIV_WIDTH-1:0]  fbdiv_q, fbdiv_d;
  logic                     gate_q, gate_d;
  logic                     done_q, done_d;
  logic                     lost_q, lost_d;
  logic                     errp_q, errp_d;
  logic                     errt_q, errt_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d, tmo_inc;
  logic [BLANK_W-1:0]       blank_q, blank_d;
  logic [STAB_W-1:0]        stab_q, stab_d, stab_inc;
  logic                     lock_s;
  logic                     accept;
  logic                     req_zero;
  logic                     busy;

`ifdef PLL_CTRL_AUTO_RETRY_EN
  localparam int unsigned RTRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  logic [RTRY_W-1:0] retry_q, retry_d;
`endif

  pll_ctrl_sync_2ff u_lock_sync (
    .clk     (clk_ref_i),
    .arst_ni (arst_ni),
    .d       (pll_locked_i),
    .q       (lock_s)
  );

  assign busy        = (state_q == ST_APPLY) || (state_q == ST_BLANK) || (state_q == ST_WAIT_LOCK);
  assign req_ready_o = (state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_FAULT);
  assign accept      = req_valid_i && req_ready_o;
  assign req_zero    = (req_refdiv_i == '0) || (req_fbdiv_i == '0);
  assign tmo_inc     = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_W'(1);
  assign stab_inc    = stab_q + STAB_W'(1);

  // Next-state and next-output logic; timeout is applied after the lock path so stable lock wins a tie.
  always_comb begin
    state_d  = state_q;
    refdiv_d = refdiv_q;
    fbdiv_d  = fbdiv_q;
    gate_d   = gate_q;
    done_d   = 1'b0;
    lost_d   = 1'b0;
    errp_d   = 1'b0;
    errt_d   = errt_q;
    tmo_d    = tmo_q;
    blank_d  = blank_q;
    stab_d   = stab_q;
`ifdef PLL_CTRL_AUTO_RETRY_EN
    retry_d  = retry_q;
`endif

    case (state_q)
      ST_APPLY: begin
        tmo_d   = tmo_inc;
        blank_d = '0;
        state_d = ST_BLANK;
      end
      ST_BLANK: begin
        tmo_d = tmo_inc;
        if (blank_q == BLANK_END) begin
          stab_d  = '0;
          state_d = ST_WAIT_LOCK;
        end else begin
          blank_d = blank_q + BLANK_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        tmo_d = tmo_inc;
        if (lock_s) begin
          stab_d = stab_inc;
          if (stab_inc == STAB_MAX) begin
            state_d = ST_RUN;
            gate_d  = 1'b1;
            done_d  = 1'b1;
`ifdef PLL_CTRL_AUTO_RETRY_EN
            retry_d = '0;
`endif
          end
        end else begin
          stab_d = '0;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          gate_d  = 1'b0;
          lost_d  = 1'b1;
          tmo_d   = '0;
          stab_d  = '0;
        end
      end
      default: ;
    endcase

    if (busy && (tmo_inc == TMO_MAX) && (state_d != ST_RUN)) begin
`ifdef PLL_CTRL_AUTO_RETRY_EN
      if (retry_q < RTRY_W'(MAX_RETRIES)) begin
        state_d = ST_APPLY;
        retry_d = retry_q + RTRY_W'(1);
        tmo_d   = '0;
      end else begin
        state_d = ST_FAULT;
        errt_d  = 1'b1;
      end
`else
      state_d = ST_FAULT;
      errt_d  = 1'b1;
`endif
    end

    if (accept) begin
      if (req_zero) begin
        errp_d = 1'b1;
      end else begin
        refdiv_d = req_refdiv_i;
        fbdiv_d  = req_fbdiv_i;
        gate_d   = 1'b0;
        lost_d   = 1'b0;
        errt_d   = 1'b0;
        tmo_d    = '0;
        state_d  = ST_APPLY;
`ifdef PLL_CTRL_AUTO_RETRY_EN
        retry_d  = '0;
`endif
      end
    end
  end

  // State, divider, flag and counter registers.
  always_ff @(posedge clk_ref_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q  <= ST_IDLE;
      refdiv_q <= REF_DIV_WIDTH'(DEFAULT_REFDIV);
      fbdiv_q  <= FB_DIV_WIDTH'(DEFAULT_FBDIV);
      gate_q   <= 1'b0;
      done_q   <= 1'b0;
      lost_q   <= 1'b0;
      errp_q   <= 1'b0;
      errt_q   <= 1'b0;
      tmo_q    <= '0;
      blank_q  <= '0;
      stab_q   <= '0;
`ifdef PLL_CTRL_AUTO_RETRY_EN
      retry_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      refdiv_q <= refdiv_d;
      fbdiv_q  <= fbdiv_d;
      gate_q   <= gate_d;
      done_q   <= done_d;
      lost_q   <= lost_d;
      errp_q   <= errp_d;
      errt_q   <= errt_d;
      tmo_q    <= tmo_d;
      blank_q  <= blank_d;
      stab_q   <= stab_d;
`ifdef PLL_CTRL_AUTO_RETRY_EN
      retry_q  <= retry_d;
`endif
    end
  end

  assign refdiv_o      = refdiv_q;
  assign fbdiv_o       = fbdiv_q;
  assign clk_gate_en_o = gate_q;
  assign busy_o        = busy;
  assign done_o        = done_q;
  assign lock_lost_o   = lost_q;
  assign err_param_o   = errp_q;
  assign err_timeout_o = errt_q;

endmodule

// File: tb/tb_pll_ctrl.sv
// Directed bench for pll_ctrl: reset, lock-up, parameter error, lock loss, timeout, glitch and reset mid-blank.
// Latency: n/a.
// Backpressure: n/a.
module tb_pll_ctrl;

  logic       arst_ni;
  logic       clk_ref_i;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_refdiv;
  logic [7:0] req_fbdiv;
  logic [3:0] refdiv;
  logic [7:0] fbdiv;
  logic       pll_locked;
  logic       clk_gate_en;
  logic       busy;
  logic       done;
  logic       lock_lost;
  logic       err_param;
  logic       err_timeout;

  int n_cmp;
  int n_err;
  int done_at;
  int lost_at;
  int tmo_at;
  int done_cnt;
  int lost_cnt;

`ifdef PLL_CTRL_AUTO_RETRY_EN
  localparam int TMO_EXP = 4 * 1024;
`else
  localparam int TMO_EXP = 1024;
`endif

  pll_ctrl dut (
    .arst_ni       (arst_ni),
    .clk_ref_i     (clk_ref_i),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_refdiv_i  (req_refdiv),
    .req_fbdiv_i   (req_fbdiv),
    .refdiv_o      (refdiv),
    .fbdiv_o       (fbdiv),
    .pll_locked_i  (pll_locked),
    .clk_gate_en_o (clk_gate_en),
    .busy_o        (busy),
    .done_o        (done),
    .lock_lost_o   (lock_lost),
    .err_param_o   (err_param),
    .err_timeout_o (err_timeout)
  );

  initial clk_ref_i = 1'b0;
  always #5 clk_ref_i = ~clk_ref_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_ref_i);
    #1;
  endtask

  // Presents one request for exactly one edge; caller ensures ready is high.
  task automatic send_req(input logic [3:0] r, input logic [7:0] f);
    req_refdiv = r;
    req_fbdiv  = f;
    req_valid  = 1'b1;
    @(posedge clk_ref_i);
    #1;
    req_valid  = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_refdiv"}, 32'(refdiv), 32'd1);
    check({tag, "_fbdiv"},  32'(fbdiv), 32'd1);
    check({tag, "_gate"},   32'(clk_gate_en), 32'd0);
    check({tag, "_ready"},  32'(req_ready), 32'd1);
    check({tag, "_busy"},   32'(busy), 32'd0);
    check({tag, "_errt"},   32'(err_timeout), 32'd0);
    check({tag, "_done"},   32'(done), 32'd0);
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    arst_ni    = 1'b0;
    req_valid  = 1'b0;
    req_refdiv = '0;
    req_fbdiv  = '0;
    pll_locked = 1'b0;

    // Reset state.
    repeat (3) tick();
    check_reset_vals("rst");
    arst_ni = 1'b1;
    repeat (2) tick();
    check_reset_vals("idle");

    // Program 2/40; lock rises 20 cycles after accept -> done 38 cycles after accept.
    send_req(4'd2, 8'd40);
    check("acc_busy", 32'(busy), 32'd1);
    check("acc_gate", 32'(clk_gate_en), 32'd0);
    check("acc_ready", 32'(req_ready), 32'd0);
    check("acc_refdiv", 32'(refdiv), 32'd2);
    check("acc_fbdiv", 32'(fbdiv), 32'd40);
    done_at = 0;
    for (int k = 1; k <= 200 && done_at == 0; k++) begin
      tick();
      if (k == 20) pll_locked = 1'b1;
      if (done) done_at = k;
      if (k == 30) check("wait_gate", 32'(clk_gate_en), 32'd0);
    end
    check("lock_done_cycle", 32'(done_at), 32'd38);
    check("lock_gate", 32'(clk_gate_en), 32'd1);
    check("lock_busy", 32'(busy), 32'd0);
    check("lock_ready", 32'(req_ready), 32'd1);
    tick();
    check("done_pulse_end", 32'(done), 32'd0);
    check("run_gate", 32'(clk_gate_en), 32'd1);

    // Zero divider in RUN: rejected, nothing else moves.
    send_req(4'd0, 8'd40);
    check("perr_pulse", 32'(err_param), 32'd1);
    check("perr_refdiv", 32'(refdiv), 32'd2);
    check("perr_fbdiv", 32'(fbdiv), 32'd40);
    check("perr_gate", 32'(clk_gate_en), 32'd1);
    check("perr_busy", 32'(busy), 32'd0);
    tick();
    check("perr_pulse_end", 32'(err_param), 32'd0);

    // Lock drops for 3 cycles in RUN: lost at 3 (sync delay + 1), relock done at 21.
    pll_locked = 1'b0;
    lost_at  = 0;
    done_at  = 0;
    lost_cnt = 0;
    for (int k = 1; k <= 100 && done_at == 0; k++) begin
      tick();
      if (k == 3) pll_locked = 1'b1;
      if (lock_lost) begin
        lost_cnt++;
        if (lost_at == 0) lost_at = k;
      end
      if (k == 3) check("lost_gate", 32'(clk_gate_en), 32'd0);
      if (k == 10) check("relock_gate_low", 32'(clk_gate_en), 32'd0);
      if (done) done_at = k;
    end
    check("lost_cycle", 32'(lost_at), 32'd3);
    check("lost_count", 32'(lost_cnt), 32'd1);
    check("relock_done_cycle", 32'(done_at), 32'd21);
    check("relock_gate", 32'(clk_gate_en), 32'd1);

    // Program 1/8 with lock never returning: timeout.
    pll_locked = 1'b0;
    send_req(4'd1, 8'd8);
    tmo_at   = 0;
    done_cnt = 0;
    for (int k = 1; k <= 6000 && tmo_at == 0; k++) begin
      tick();
      if (done) done_cnt++;
      if (err_timeout) tmo_at = k;
    end
    check("tmo_cycle", 32'(tmo_at), 32'(TMO_EXP));
    check("tmo_no_done", 32'(done_cnt), 32'd0);
    check("tmo_gate", 32'(clk_gate_en), 32'd0);
    check("tmo_ready", 32'(req_ready), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_refdiv", 32'(refdiv), 32'd1);
    check("tmo_fbdiv", 32'(fbdiv), 32'd8);
    repeat (5) tick();
    check("tmo_sticky", 32'(err_timeout), 32'd1);

    // New request from FAULT clears the timeout; a 5-cycle lock glitch must not complete lock.
    send_req(4'd3, 8'd50);
    check("tmo_clear", 32'(err_timeout), 32'd0);
    done_cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k == 12) pll_locked = 1'b1;
      if (k == 17) pll_locked = 1'b0;
      if (done) done_cnt++;
    end
    check("glitch_no_done", 32'(done_cnt), 32'd0);
    check("glitch_busy", 32'(busy), 32'd1);
    check("glitch_gate", 32'(clk_gate_en), 32'd0);
    arst_ni = 1'b0;
    #2;
    check_reset_vals("rst_wait");
    arst_ni = 1'b1;
    tick();

    // Reset asserted mid-BLANK returns to reset values immediately.
    send_req(4'd4, 8'd60);
    repeat (4) tick();
    check("blank_busy", 32'(busy), 32'd1);
    check("blank_refdiv", 32'(refdiv), 32'd4);
    arst_ni = 1'b0;
    #2;
    check_reset_vals("rst_blank");
    arst_ni = 1'b1;
    done_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (done) done_cnt++;
    end
    check("post_rst_no_done", 32'(done_cnt), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
